// File: rtl/noaa_result_monitor.sv
// noaa_result_monitor
//   Buffers results from the averaging stage in a small FIFO, tagging each
//   entry with the mode (average / std-dev) that produced it.  It also keeps
//   running min/max of average results, hysteretic high/low temperature
//   alarms, and a volatility flag driven by std-dev results.
//
// Ports
//   CLK          sole clock, all state on rising edge
//   RESET_N      synchronous active-low reset
//   DONE         result-valid pulse from averaging stage
//   AVG_SD       result value, valid when DONE=1
//   MODE         mode fed to averaging stage (0=average, 1=std-dev)
//   HI_THRESH    high-temperature alarm threshold
//   LO_THRESH    low-temperature alarm threshold
//   CLEAR_STATS  clears MIN_AVG/MAX_AVG/OVERFLOW
//   RD_EN        FIFO pop request
//   RD_DATA      {mode tag, value} of the last popped entry
//   RD_VALID     one-cycle pulse when RD_DATA was just loaded
//   EMPTY/FULL   FIFO status
//   COUNT        FIFO occupancy, 0..DEPTH
//   OVERFLOW     sticky: a result was dropped while full
//   MIN_AVG      minimum average result since clear
//   MAX_AVG      maximum average result since clear
//   HI_ALARM     high-temperature alarm
//   LO_ALARM     low-temperature alarm
//   VOLATILE     last std-dev result exceeded SD_LIMIT
module noaa_result_monitor #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [11:0] HYST     = 12'd16,
    parameter logic [11:0] SD_LIMIT = 12'd64
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     DONE,
    input  logic [11:0]              AVG_SD,
    input  logic                     MODE,
    input  logic [11:0]              HI_THRESH,
    input  logic [11:0]              LO_THRESH,
    input  logic                     CLEAR_STATS,
    input  logic                     RD_EN,
    output logic [12:0]              RD_DATA,
    output logic                     RD_VALID,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVERFLOW,
    output logic [11:0]              MIN_AVG,
    output logic [11:0]              MAX_AVG,
    output logic                     HI_ALARM,
    output logic                     LO_ALARM,
    output logic                     VOLATILE
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [1:0]    tag_pipe;
    logic          tag;
    logic [12:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_next;
    logic          pop_ok;
    logic          wr_ok;
    logic          drop;
    logic          avg_done;
    logic [11:0]   hi_clr_level;
    logic [12:0]   lo_sum;
    logic [11:0]   lo_clr_level;

    // Tag lines up with the averaging stage's two-cycle latency.
    assign tag = tag_pipe[1];

    assign EMPTY    = (COUNT == '0);
    assign FULL     = (COUNT == (AW+1)'(DEPTH));
    assign pop_ok   = RD_EN && !EMPTY;
    // A same-cycle pop frees the slot, so a write into a full FIFO is accepted.
    assign wr_ok    = DONE && (!FULL || pop_ok);
    assign drop     = DONE && FULL && !pop_ok;
    assign avg_done = DONE && !tag;

    // Alarm release levels, saturating at the ends of the 12-bit range.
    assign hi_clr_level = (HI_THRESH > HYST) ? (HI_THRESH - HYST) : '0;
    assign lo_sum       = {1'b0, LO_THRESH} + {1'b0, HYST};
    assign lo_clr_level = lo_sum[12] ? 12'hFFF : lo_sum[11:0];

    always_comb begin
        count_next = COUNT;
        if (wr_ok && !pop_ok)
            count_next = COUNT + 1'b1;
        else if (!wr_ok && pop_ok)
            count_next = COUNT - 1'b1;
    end

    // Storage array needs no reset; pointers and COUNT define validity.
    always_ff @(posedge CLK) begin
        if (RESET_N && wr_ok)
            mem[wr_ptr] <= {tag, AVG_SD};
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            tag_pipe <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            COUNT    <= '0;
            RD_DATA  <= '0;
            RD_VALID <= 1'b0;
        end else begin
            tag_pipe <= {tag_pipe[0], MODE};
            COUNT    <= count_next;
            RD_VALID <= pop_ok;
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) begin
                rd_ptr  <= rd_ptr + 1'b1;
                RD_DATA <= mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            OVERFLOW <= 1'b0;
            MIN_AVG  <= 12'hFFF;
            MAX_AVG  <= '0;
            HI_ALARM <= 1'b0;
            LO_ALARM <= 1'b0;
            VOLATILE <= 1'b0;
        end else begin
            // A drop in the same cycle as a clear leaves OVERFLOW set.
            if (drop)
                OVERFLOW <= 1'b1;
            else if (CLEAR_STATS)
                OVERFLOW <= 1'b0;

            if (CLEAR_STATS) begin
                MIN_AVG <= avg_done ? AVG_SD : 12'hFFF;
                MAX_AVG <= avg_done ? AVG_SD : '0;
            end else if (avg_done) begin
                if (AVG_SD < MIN_AVG)
                    MIN_AVG <= AVG_SD;
                if (AVG_SD > MAX_AVG)
                    MAX_AVG <= AVG_SD;
            end

            if (avg_done) begin
                if (AVG_SD > HI_THRESH)
                    HI_ALARM <= 1'b1;
                else if (AVG_SD <= hi_clr_level)
                    HI_ALARM <= 1'b0;

                if (AVG_SD < LO_THRESH)
                    LO_ALARM <= 1'b1;
                else if (AVG_SD >= lo_clr_level)
                    LO_ALARM <= 1'b0;
            end

            if (DONE && tag)
                VOLATILE <= (AVG_SD > SD_LIMIT);
        end
    end

endmodule
